// File: rtl/sockit_ghrd_onchip_ram_pkg.sv
// Shared types and constants for the pipelined on-chip RAM slave.
package sockit_ghrd_onchip_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam int RL_SHORT = 1;
  localparam int RL_LONG  = 2;

  function automatic bit rl_legal(int rl);
    return (rl == RL_SHORT) || (rl == RL_LONG);
  endfunction

endpackage

// File: rtl/sockit_ghrd_onchip_ram_pipe_ram_sp.sv
// Single-port byte-enabled RAM with a registered read port (one cycle latency).
module sockit_ghrd_ram_sp #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 13
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // No reset on the array or read register so the tools map this onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sockit_ghrd_onchip_ram_pipe.sv
// Avalon-MM style on-chip RAM slave: optional zero-fill after reset, pipelined reads, freeze.
module sockit_ghrd_onchip_ram_pipe
  import sockit_ghrd_onchip_ram_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 13,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                freeze,
  output logic                waitrequest,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                clear_done
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic RST_DONE = logic'(CLEAR_ON_RESET == 0);

  if (!rl_legal(READ_LATENCY) || (DATA_W % 8) != 0) begin : g_param_err
    $error("sockit_ghrd_onchip_ram_pipe: READ_LATENCY must be 1 or 2 and DATA_W a multiple of 8");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              done_q, done_d;
  logic              v1_q, v1_d;
  logic              clearing, rd_acc, wr_acc;
  logic              ram_we;
  logic [NB-1:0]     ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign clearing    = (state_q == ST_CLEAR);
  // Reset is folded in so the slave also reports busy while held in reset.
  assign waitrequest = ~reset_n | clearing | freeze;
  assign rd_acc      = chipselect & read & ~write & ~waitrequest;
  assign wr_acc      = chipselect & write & ~waitrequest;
  assign clear_done  = reset_n & done_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    done_d    = done_q;
    v1_d      = rd_acc;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == LAST_ADDR) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
      done_q    <= RST_DONE;
      v1_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      done_q    <= done_d;
      v1_q      <= v1_d;
    end
  end

  assign ram_we    = clearing | wr_acc;
  assign ram_be    = clearing ? '1 : byteenable;
  assign ram_addr  = clearing ? clr_cnt_q : address;
  assign ram_wdata = clearing ? '0 : writedata;

  sockit_ghrd_ram_sp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  if (READ_LATENCY == RL_LONG) begin : g_rl2
    logic              v2_q, v2_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;

    always_comb begin
      v2_d  = v1_q;
      rd2_d = v1_q ? ram_rdata : rd2_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v2_q  <= 1'b0;
        rd2_q <= '0;
      end else begin
        v2_q  <= v2_d;
        rd2_q <= rd2_d;
      end
    end

    assign readdatavalid = v2_q;
    assign readdata      = rd2_q;
  end else begin : g_rl1
    // RAM output register carries no reset, so a shadow copy holds the last word.
    logic [DATA_W-1:0] hold_q, hold_d;

    always_comb begin
      hold_d = v1_q ? ram_rdata : hold_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) hold_q <= '0;
      else          hold_q <= hold_d;
    end

    assign readdatavalid = v1_q;
    assign readdata      = v1_q ? ram_rdata : hold_q;
  end

endmodule

// File: tb/tb_sockit_ghrd_onchip_ram_pipe.sv
// Scoreboard bench: reads push expected word and arrival cycle; a monitor pops on readdatavalid.
module tb_sockit_ghrd_onchip_ram_pipe;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          chipselect, read, write, freeze;
  logic [DW-1:0] writedata;
  logic          waitrequest, readdatavalid, clear_done;
  logic [DW-1:0] readdata;

  sockit_ghrd_onchip_ram_pipe #(
    .DATA_W         (DW),
    .ADDR_W         (AW),
    .READ_LATENCY   (RL),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .byteenable    (byteenable),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .freeze        (freeze),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .clear_done    (clear_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] wtab [8] = '{32'h0F0F_0000, 32'h1E1E_1111, 32'h2D2D_2222, 32'h3C3C_3333,
                            32'h4B4B_4444, 32'h5A5A_5555, 32'h6969_6666, 32'h7878_7777};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every readdatavalid pulse must match the oldest expectation in data and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (readdatavalid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd_unexpected: got readdatavalid with data %h at cycle %0d, required none", readdata, cyc);
        end else begin
          e = sb_q.pop_front();
          $display("RD  data=%h cycle=%0d (expected %h at %0d)", readdata, cyc, e.data, e.cyc);
          check("rd_data", readdata, e.data);
          check("rd_cycle", cyc, e.cyc);
        end
      end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL rd_missing: got no readdatavalid at cycle %0d, required data %h", cyc, e.data);
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0; write = 1'b0; freeze = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clk); #1;
    chipselect = 1'b1; read = 1'b0; write = 1'b1;
    address = a; writedata = d; byteenable = be;
    $display("WR  addr=%0d data=%h be=%h cycle=%0d", a, d, be, cyc);
    #1 check("wr_waitrequest", waitrequest, 1'b0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    sb_q.push_back('{exp, cyc + RL});
    $display("RDQ addr=%0d cycle=%0d", a, cyc);
    #1 check("rd_waitrequest", waitrequest, 1'b0);
  endtask

  task automatic do_rw(input logic [AW-1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; read = 1'b1; write = 1'b1;
    address = a; writedata = d; byteenable = 4'hF;
    $display("RW  addr=%0d data=%h cycle=%0d", a, d, cyc);
    #1 check("rw_waitrequest", waitrequest, 1'b0);
  endtask

  // Called right after reset release: 16 busy cycles, clear_done in the 17th.
  task automatic wait_clear(input string tag);
    for (int i = 0; i < 16; i++) begin
      #1;
      check({tag, "_busy"}, waitrequest, 1'b1);
      check({tag, "_not_done"}, clear_done, 1'b0);
      @(negedge clk);
    end
    #1;
    check({tag, "_done"}, clear_done, 1'b1);
    check({tag, "_ready"}, waitrequest, 1'b0);
    $display("CLR %s complete at cycle %0d", tag, cyc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdv"}, readdatavalid, 1'b0);
    check({tag, "_rdata"}, readdata, 32'h0);
    check({tag, "_wait"}, waitrequest, 1'b1);
    check({tag, "_cdone"}, clear_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0; freeze = 1'b0;
    address = '0; byteenable = '0; writedata = '0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("por");

    @(negedge clk); #2 reset_n = 1'b1;
    wait_clear("clr1");

    for (int a = 0; a < 16; a++) do_read(AW'(a), 32'h0);
    idle();

    do_write(4'd3, 32'hAABB_CCDD, 4'hF);
    do_write(4'd3, 32'h1122_3344, 4'h5);
    do_read(4'd3, 32'hAA22_CC44);
    idle();

    for (int a = 0; a < 8; a++) do_write(AW'(a), wtab[a], 4'hF);
    for (int a = 0; a < 8; a++) do_read(AW'(a), wtab[a]);
    idle();

    do_rw(4'd5, 32'h1234_5678);
    idle();
    repeat (RL + 2) @(posedge clk);
    do_read(4'd5, 32'h1234_5678);
    idle();

    do_read(4'd0, wtab[0]);
    do_read(4'd1, wtab[1]);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 4'd2; freeze = 1'b1;
      #1 check("frozen_wait", waitrequest, 1'b1);
    end
    idle();
    repeat (4) @(negedge clk);
    #1 check("rd_hold", readdata, wtab[1]);

    @(negedge clk); #2 reset_n = 1'b0;
    #1 check_reset_outputs("rst_idle");
    @(negedge clk); #2 reset_n = 1'b1;
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk); #2 reset_n = 1'b1;
    wait_clear("clr2");

    do_read(4'd9, 32'h0);
    do_read(4'd3, 32'h0);
    do_read(4'd5, 32'h0);
    idle();

    repeat (6) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sockit_ghrd_onchip_ram_pipe.md
SOCKIT_GHRD_ONCHIP_RAM_PIPE -- requirements
Module: sockit_ghrd_onchip_ram_pipe

Interface
REQ-001 Parameter DATA_W, default 64, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 13, word address width; depth SHALL be 2**ADDR_W words.
REQ-003 Parameter READ_LATENCY, default 1, legal values 1 or 2, cycles from read accept to readdatavalid.
REQ-004 Parameter CLEAR_ON_RESET, default 1, 1 = zero-fill entire array after reset.
REQ-005 Port clk, input, 1, single clock for all logic.
REQ-006 Port reset_n, input, 1, asynchronous active-low reset.
REQ-007 Port address, input, ADDR_W, word address.
REQ-008 Port byteenable, input, DATA_W/8, per-byte write enable.
REQ-009 Port chipselect, input, 1, slave select.
REQ-010 Port read, input, 1, read request.
REQ-011 Port write, input, 1, write request.
REQ-012 Port writedata, input, DATA_W, write data.
REQ-013 Port freeze, input, 1, 1 = refuse new transfers.
REQ-014 Port waitrequest, output, 1, 1 = transfer not accepted this cycle.
REQ-015 Port readdata, output, DATA_W, read data.
REQ-016 Port readdatavalid, output, 1, readdata qualifier.
REQ-017 Port clear_done, output, 1, 1 = initial clear complete.

Function
REQ-018 FSM states CLEAR and IDLE; after reset, state SHALL be CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
REQ-019 In CLEAR, one word per cycle SHALL be written with zero, address counter 0 to 2**ADDR_W-1, all bytes enabled.
REQ-020 After writing the last address, CLEAR SHALL transition to IDLE next cycle; clear_done SHALL rise in that same cycle and stay 1 until reset.
REQ-021 With CLEAR_ON_RESET=0, clear_done SHALL be 1 from the first cycle after reset release.
REQ-022 waitrequest SHALL be 1 when state is CLEAR or freeze=1, else 0 (combinational, no dependency on read/write).
REQ-023 Transfer accepted when chipselect=1, (read or write)=1, waitrequest=0.
REQ-024 Accepted write SHALL update only bytes whose byteenable bit is 1, visible to a read accepted the following cycle.
REQ-025 If read and write are both 1, write SHALL be performed and read SHALL be ignored (no readdatavalid).
REQ-026 Accepted read SHALL produce readdatavalid=1 for exactly one cycle, exactly READ_LATENCY cycles after accept, with the addressed word.
REQ-027 Reads SHALL be fully pipelined: one accept per cycle, readdatavalid order equals accept order.
REQ-028 Write accepted cycle N, read same address cycle N+1: read SHALL return written data.
REQ-029 freeze asserted with reads in flight: in-flight reads SHALL still complete at their scheduled cycle.
REQ-030 readdata SHALL hold its last value when readdatavalid=0.

Reset
REQ-031 On reset_n=0: readdatavalid=0, readdata=0, waitrequest=1, clear_done=0, in-flight reads discarded, clear counter=0.
REQ-032 Reset mid-clear SHALL restart clear from address 0 after release; RAM contents are not reset except by clear.

Structure
REQ-033 Package sockit_ghrd_onchip_ram_pkg SHALL hold the FSM state typedef and legal READ_LATENCY constants.
REQ-034 One sub-module sockit_ghrd_ram_sp: inferable single-port byte-enabled RAM with registered read (latency 1); READ_LATENCY=2 adds one output register in the top.
REQ-035 Elaboration SHALL fail for READ_LATENCY outside {1,2} or DATA_W not multiple of 8.

Verification (ADDR_W=4, DATA_W=32)
REQ-036 Release reset, CLEAR_ON_RESET=1 -> waitrequest=1 for 16 cycles, clear_done=1 in 17th cycle, read of all 16 addresses returns 0x00000000.
REQ-037 Write 0xAABBCCDD to addr 3 byteenable 0xF, then 0x11223344 with byteenable 0x5 -> read addr 3 returns 0xAA22CC44.
REQ-038 Back-to-back reads addr 0..7, READ_LATENCY=2 -> readdatavalid high 8 consecutive cycles starting 2 cycles after first accept, data in order.
REQ-039 Read and write both 1 to addr 5 with 0x12345678 -> no readdatavalid; subsequent read returns 0x12345678.
REQ-040 Issue 2 reads then freeze=1 -> both readdatavalid pulses delivered, waitrequest=1 while frozen, no new accepts.
REQ-041 Assert reset_n=0 at clear address 9 -> readdatavalid=0 immediately; after release clear restarts at 0, clear_done after 16 cycles.
